// File: rtl/vga_rgb_prefetch.sv
// Streams a packed 320x240 RGB frame out of SRAM (3 big-endian words per 2 pixels)
// into a small pixel FIFO that the VGA controller drains one pixel per handshake.
module vga_rgb_prefetch #(
  parameter int NUM_PIXELS = 76800,
  parameter int FIFO_DEPTH = 8,
  parameter int SRAM_LAT   = 2
) (
  input  logic        Clock_50,
  input  logic        Reset,
  input  logic        Start,
  input  logic [17:0] Base_address,
  input  logic [15:0] SRAM_read_data,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  output logic        Pix_valid,
  input  logic        Pix_ready,
  output logic [7:0]  Pix_R,
  output logic [7:0]  Pix_G,
  output logic [7:0]  Pix_B,
  output logic        Busy,
  output logic        Frame_done
);

  localparam int TOTAL_WORDS = 3 * NUM_PIXELS / 2;
  localparam int WCW = $clog2(TOTAL_WORDS + 1);
  localparam int PCW = $clog2(NUM_PIXELS + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t state, state_next;

  logic                iss_valid;
  logic [1:0]          iss_phase;
  logic [WCW-1:0]      word_cnt;
  logic [SRAM_LAT-1:0] pipe_valid;
  logic [1:0]          pipe_phase [SRAM_LAT];
  logic [7:0]          hold_r0, hold_g0, hold_r1;
  logic [23:0]         fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       fifo_count, pending;
  logic [PCW-1:0]      pop_cnt;

  logic        issue_next, group_start, mid_group, words_left, space_ok;
  logic        push, pop, last_pop;
  logic [1:0]  phase_next;
  logic [23:0] push_data, head;

  assign pop        = Pix_valid & Pix_ready;
  assign push       = pipe_valid[SRAM_LAT-1] && (pipe_phase[SRAM_LAT-1] != 2'd0);
  assign last_pop   = pop && (pop_cnt == PCW'(NUM_PIXELS - 1)) && (state == S_DRAIN);
  assign mid_group  = iss_valid && (iss_phase != 2'd2);
  assign words_left = (word_cnt != WCW'(TOTAL_WORDS));
  // Pending pixels are reserved when a group starts so the FIFO can never overflow.
  assign space_ok   = (int'(fifo_count) + int'(pending) + 2) <= FIFO_DEPTH;

  always_comb begin
    state_next  = state;
    issue_next  = 1'b0;
    group_start = 1'b0;
    phase_next  = 2'd0;
    if (Start) begin
      state_next  = S_FETCH;
      issue_next  = 1'b1;
      group_start = 1'b1;
    end else begin
      case (state)
        S_FETCH: begin
          if (mid_group) begin
            issue_next = 1'b1;
            phase_next = iss_phase + 2'd1;
          end else if (!words_left) begin
            state_next = S_DRAIN;
          end else if (space_ok) begin
            issue_next  = 1'b1;
            group_start = 1'b1;
          end
        end
        S_DRAIN: if (last_pop) state_next = S_IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    push_data = {hold_r1, SRAM_read_data};
    if (pipe_phase[SRAM_LAT-1] == 2'd1) push_data = {hold_r0, hold_g0, SRAM_read_data[15:8]};
  end

  always_ff @(posedge Clock_50) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      SRAM_address <= '0;
      iss_valid    <= 1'b0;
      iss_phase    <= 2'd0;
      word_cnt     <= '0;
      pipe_valid   <= '0;
      for (int i = 0; i < SRAM_LAT; i++) pipe_phase[i] <= 2'd0;
      hold_r0      <= '0;
      hold_g0      <= '0;
      hold_r1      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      pending      <= '0;
      pop_cnt      <= '0;
      Busy         <= 1'b0;
      Frame_done   <= 1'b0;
    end else begin
      iss_valid <= issue_next;
      iss_phase <= phase_next;
      if (issue_next) begin
        SRAM_address <= Start ? Base_address : SRAM_address + 18'd1;
        word_cnt     <= Start ? WCW'(1) : word_cnt + WCW'(1);
      end

      pipe_phase[0] <= iss_phase;
      for (int i = 1; i < SRAM_LAT; i++) pipe_phase[i] <= pipe_phase[i-1];

      if (pipe_valid[SRAM_LAT-1]) begin
        if (pipe_phase[SRAM_LAT-1] == 2'd0) begin
          hold_r0 <= SRAM_read_data[15:8];
          hold_g0 <= SRAM_read_data[7:0];
        end else if (pipe_phase[SRAM_LAT-1] == 2'd1) begin
          hold_r1 <= SRAM_read_data[7:0];
        end
      end

      // A restart throws away everything belonging to the old frame, including its in-flight reads.
      if (Start) begin
        pipe_valid <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        pending    <= CW'(2);
        pop_cnt    <= '0;
      end else begin
        pipe_valid <= {pipe_valid[SRAM_LAT-2:0], iss_valid};
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr  <= rd_ptr + AW'(1);
          pop_cnt <= pop_cnt + PCW'(1);
        end
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + CW'(1);
          2'b01:   fifo_count <= fifo_count - CW'(1);
          default: ;
        endcase
        case ({group_start, push})
          2'b10:   pending <= pending + CW'(2);
          2'b01:   pending <= pending - CW'(1);
          2'b11:   pending <= pending + CW'(1);
          default: ;
        endcase
      end

      Frame_done <= last_pop;
      if (Start)                             Busy <= 1'b1;
      else if (Frame_done && state == S_IDLE) Busy <= 1'b0;
    end
  end

  always_ff @(posedge Clock_50) begin
    if (!Reset && !Start && push) fifo_mem[wr_ptr] <= push_data;
  end

  assign head      = fifo_mem[rd_ptr];
  assign Pix_valid = (fifo_count != '0);
  assign Pix_R     = Pix_valid ? head[23:16] : 8'd0;
  assign Pix_G     = Pix_valid ? head[15:8]  : 8'd0;
  assign Pix_B     = Pix_valid ? head[7:0]   : 8'd0;
  assign SRAM_we_n = 1'b1;

  assert property (@(posedge Clock_50) disable iff (Reset) fifo_count <= CW'(FIFO_DEPTH));

endmodule
